// File: rtl/rpn_cmd_serializer.sv
// rpn_cmd_serializer: parallel-to-serial command feeder for the RPN calculator.
// Accepts opcode + operand over valid/ready, emits a pulse-coded frame on a
// single registered line, then holds the line low for a separating gap (longer
// after ENTER so the calculator's result frame can finish).
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   high only while idle
//   cmd_op      0=PUSH 1=CLEAR 2=ADD 3=MULT 4=ENTER, 5..7 illegal
//   cmd_data    PUSH operand
//   dout        serial line to calculator dIn (registered)
//   busy        frame or gap in progress
//   err_illegal one-cycle pulse after an illegal opcode is accepted
module rpn_cmd_serializer #(
  parameter int unsigned GAP        = 10,
  parameter int unsigned ENTER_WAIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       dout,
  output logic       busy,
  output logic       err_illegal
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  // Gap counter is loaded with G-1 on entry and leaves at 1, giving G low edges.
  localparam logic [7:0] GapNormLd  = 8'(GAP - 1);
  localparam logic [7:0] GapEnterLd = 8'(GAP + ENTER_WAIT - 1);

  state_e      state_q, state_d;
  logic [9:0]  sr_q, sr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        enter_q, enter_d;
  logic        dout_q, dout_d;
  logic        err_q, err_d;

  logic [9:0]  pat;
  logic [7:0]  pat_len;
  logic        pat_legal;
  logic        pat_enter;
  logic        accept;

  // Left-aligned frame pattern for the presented opcode.
  always_comb begin
    pat       = '0;
    pat_len   = 8'd0;
    pat_legal = 1'b1;
    pat_enter = 1'b0;
    case (cmd_op)
      3'd0: begin pat = {2'b10, cmd_data}; pat_len = 8'd10; end
      3'd1: begin pat = 10'b11_0000_0000;  pat_len = 8'd2;  end
      3'd2: begin pat = 10'b1101_000000;   pat_len = 8'd4;  end
      3'd3: begin pat = 10'b111_0000000;   pat_len = 8'd3;  end
      3'd4: begin pat = 10'b1111_000000;   pat_len = 8'd4;  pat_enter = 1'b1; end
      default: pat_legal = 1'b0;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid & cmd_ready;

  // cnt_q in StShift holds the number of frame bits still to emit after the
  // one currently on dout; in StGap it counts down the remaining low cycles.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    enter_d = enter_q;
    dout_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (pat_legal) begin
            dout_d  = pat[9];
            sr_d    = {pat[8:0], 1'b0};
            cnt_d   = pat_len - 8'd1;
            enter_d = pat_enter;
            state_d = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = enter_q ? GapEnterLd : GapNormLd;
          state_d = StGap;
        end else begin
          dout_d = sr_q[9];
          sr_d   = {sr_q[8:0], 1'b0};
          cnt_d  = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      dout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign dout        = dout_q;
  assign busy        = (state_q != StIdle);
  assign err_illegal = err_q;

endmodule
